wbu_commit: RTL and testbench

WBU_COMMIT -- requirements
Module: wbu_commit

---
 rtl/wbu_commit.sv | 151 +++++++++++++++
 tb/tb_wbu_commit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wbu_commit.sv
// wbu_commit: write-back/commit stage. Accepts one upstream result per cycle,
// waits for memory data on loads, and issues a single-cycle register-file
// write plus retire pulse for every accepted instruction.
// Optional build macro: WBU_LOAD_EXT_EN adds byte/halfword lane selection and
// sign/zero extension of load data; without it the raw memory word is written.
module wbu_commit (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        wen_i,
  input  logic [4:0]  rd_i,
  input  logic        load_i,
  input  logic [2:0]  ldop_i,
  input  logic [31:0] result_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_rready_o,
  output logic        wena_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o,
  output logic        retire_o
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned OPW  = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            wen_q, wen_nxt;
  logic [RW-1:0]   rd_q, rd_nxt;
  logic [OPW-1:0]  ldop_q, ldop_nxt;
  logic [1:0]      off_q, off_nxt;
  logic            ready_nxt, mem_rready_nxt, wena_nxt, retire_nxt;
  logic [RW-1:0]   waddr_nxt;
  logic [XLEN-1:0] wdata_nxt;
  logic [XLEN-1:0] load_data_c;
  logic            accept_c;

`ifdef WBU_LOAD_EXT_EN
  // Select the addressed byte/halfword lane and extend it per funct3.
  function automatic logic [XLEN-1:0] load_fmt(input logic [OPW-1:0] op,
                                               input logic [1:0]     off,
                                               input logic [XLEN-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (op)
      3'b000:  load_fmt = {{24{b[7]}}, b};
      3'b001:  load_fmt = {{16{h[15]}}, h};
      3'b010:  load_fmt = word;
      3'b100:  load_fmt = {24'd0, b};
      3'b101:  load_fmt = {16'd0, h};
      default: load_fmt = word;
    endcase
  endfunction

  assign load_data_c = load_fmt(ldop_q, off_q, mem_rdata_i);
`else
  // Extension compiled out: the raw word is written; op and offset go unused.
  logic unused_ext;
  assign unused_ext  = ^{ldop_q, off_q};
  assign load_data_c = mem_rdata_i;
`endif

  assign accept_c = valid_i & ready_o;

  // State, latched fields and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      wen_q        <= 1'b0;
      rd_q         <= '0;
      ldop_q       <= '0;
      off_q        <= '0;
      ready_o      <= 1'b0;
      mem_rready_o <= 1'b0;
      wena_o       <= 1'b0;
      waddr_o      <= '0;
      wdata_o      <= '0;
      retire_o     <= 1'b0;
    end else begin
      state        <= state_nxt;
      wen_q        <= wen_nxt;
      rd_q         <= rd_nxt;
      ldop_q       <= ldop_nxt;
      off_q        <= off_nxt;
      ready_o      <= ready_nxt;
      mem_rready_o <= mem_rready_nxt;
      wena_o       <= wena_nxt;
      waddr_o      <= waddr_nxt;
      wdata_o      <= wdata_nxt;
      retire_o     <= retire_nxt;
    end
  end

  // Next state and next-cycle outputs; write outputs are set only when entering COMMIT.
  always_comb begin
    state_nxt  = state;
    wen_nxt    = wen_q;
    rd_nxt     = rd_q;
    ldop_nxt   = ldop_q;
    off_nxt    = off_q;
    wena_nxt   = 1'b0;
    waddr_nxt  = '0;
    wdata_nxt  = '0;
    retire_nxt = 1'b0;

    case (state)
      IDLE, COMMIT: begin
        state_nxt = IDLE;
        if (accept_c) begin
          wen_nxt  = wen_i;
          rd_nxt   = rd_i;
          ldop_nxt = ldop_i;
          off_nxt  = result_i[1:0];
          if (load_i) begin
            state_nxt = WAIT_MEM;
          end else begin
            state_nxt  = COMMIT;
            wena_nxt   = wen_i & (rd_i != '0);
            waddr_nxt  = rd_i;
            wdata_nxt  = result_i;
            retire_nxt = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid_i) begin
          state_nxt  = COMMIT;
          wena_nxt   = wen_q & (rd_q != '0);
          waddr_nxt  = rd_q;
          wdata_nxt  = load_data_c;
          retire_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    ready_nxt      = (state_nxt != WAIT_MEM);
    mem_rready_nxt = (state_nxt == WAIT_MEM);
  end

endmodule

// File: tb/tb_wbu_commit.sv
// Directed bench for wbu_commit; expected values hand-computed, with the
// load-extension expectations selected by WBU_LOAD_EXT_EN.
module tb_wbu_commit;

  logic        clock;
  logic        reset;
  logic        valid_i;
  logic        ready_o;
  logic        wen_i;
  logic [4:0]  rd_i;
  logic        load_i;
  logic [2:0]  ldop_i;
  logic [31:0] result_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_rready_o;
  logic        wena_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        retire_o;

  int total;
  int bad;

  wbu_commit dut (
    .clock        (clock),
    .reset        (reset),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .wen_i        (wen_i),
    .rd_i         (rd_i),
    .load_i       (load_i),
    .ldop_i       (ldop_i),
    .result_i     (result_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_rready_o (mem_rready_o),
    .wena_o       (wena_o),
    .waddr_o      (waddr_o),
    .wdata_o      (wdata_o),
    .retire_o     (retire_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count one comparison and report it if it differs.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock edge; return 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_op(input logic ld, input logic [2:0] op, input logic w,
                          input logic [4:0] rd, input logic [31:0] res);
    valid_i  = 1'b1;
    load_i   = ld;
    ldop_i   = op;
    wen_i    = w;
    rd_i     = rd;
    result_i = res;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".wena"},   32'(wena_o),   32'd0);
    check({tag, ".retire"}, 32'(retire_o), 32'd0);
    check({tag, ".waddr"},  32'(waddr_o),  32'd0);
    check({tag, ".wdata"},  wdata_o,       32'd0);
  endtask

  task automatic check_write(input string tag, input logic we, input logic [4:0] ra,
                             input logic [31:0] wd);
    check({tag, ".wena"},   32'(wena_o),   32'(we));
    check({tag, ".retire"}, 32'(retire_o), 32'd1);
    check({tag, ".waddr"},  32'(waddr_o),  32'(ra));
    check({tag, ".wdata"},  wdata_o,       wd);
  endtask

  logic [31:0] exp_lb, exp_lhu, exp_lh;

  initial begin
    total = 0;
    bad   = 0;
`ifdef WBU_LOAD_EXT_EN
    exp_lb  = 32'hFFFF_FF80;
    exp_lhu = 32'h0000_BEEF;
    exp_lh  = 32'hFFFF_8001;
`else
    exp_lb  = 32'h80FF_FF7F;
    exp_lhu = 32'hBEEF_1234;
    exp_lh  = 32'h0000_8001;
`endif
    reset = 1'b0; valid_i = 1'b0; wen_i = 1'b0; rd_i = '0; load_i = 1'b0;
    ldop_i = '0; result_i = '0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;

    // Reset state
    step(); step();
    check("rst.ready", 32'(ready_o), 32'd0);
    check("rst.mrdy",  32'(mem_rready_o), 32'd0);
    check_quiet("rst");
    reset = 1'b1;
    step();
    check("rel.ready", 32'(ready_o), 32'd1);
    check("rel.mrdy",  32'(mem_rready_o), 32'd0);

    // Back-to-back ALU pair
    drive_op(1'b0, 3'b000, 1'b1, 5'd5, 32'h11);
    step();
    check_write("alu1", 1'b1, 5'd5, 32'h11);
    check("alu1.ready", 32'(ready_o), 32'd1);
    drive_op(1'b0, 3'b000, 1'b1, 5'd6, 32'h22);
    step();
    check_write("alu2", 1'b1, 5'd6, 32'h22);
    check("alu2.ready", 32'(ready_o), 32'd1);
    valid_i = 1'b0;
    step();
    check_quiet("alu.idle");

    // LB from byte lane 3
    drive_op(1'b1, 3'b000, 1'b1, 5'd7, 32'h0000_1003);
    step();
    check("lb.ready", 32'(ready_o), 32'd0);
    check("lb.mrdy",  32'(mem_rready_o), 32'd1);
    check_quiet("lb.wait");
    valid_i = 1'b0;
    step();
    check("lb.ready2", 32'(ready_o), 32'd0);
    check_quiet("lb.wait2");
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h80FF_FF7F;
    step();
    mem_rvalid_i = 1'b0;
    check_write("lb", 1'b1, 5'd7, exp_lb);
    check("lb.ready3", 32'(ready_o), 32'd1);
    check("lb.mrdy3",  32'(mem_rready_o), 32'd0);

    // LHU accepted in the COMMIT cycle of the LB
    drive_op(1'b1, 3'b101, 1'b1, 5'd8, 32'h0000_2002);
    step();
    valid_i = 1'b0;
    check("lhu.ready", 32'(ready_o), 32'd0);
    check_quiet("lhu.wait");
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBEEF_1234;
    step();
    mem_rvalid_i = 1'b0;
    check_write("lhu", 1'b1, 5'd8, exp_lhu);

    // LH from lower half, negative value
    drive_op(1'b1, 3'b001, 1'b1, 5'd9, 32'h0000_3000);
    step();
    valid_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_8001;
    step();
    mem_rvalid_i = 1'b0;
    check_write("lh", 1'b1, 5'd9, exp_lh);
    step();
    check_quiet("lh.after");

    // Write to x0 still retires without a write enable
    drive_op(1'b0, 3'b000, 1'b1, 5'd0, 32'hDEAD_BEEF);
    step();
    valid_i = 1'b0;
    check_write("x0", 1'b0, 5'd0, 32'hDEAD_BEEF);
    step();
    check("x0.once", 32'(retire_o), 32'd0);

    // wen=0 retires without a write
    drive_op(1'b0, 3'b000, 1'b0, 5'd12, 32'h0000_0055);
    step();
    valid_i = 1'b0;
    check_write("nowen", 1'b0, 5'd12, 32'h0000_0055);

    // Stray memory response in IDLE
    step();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    step();
    check_quiet("stray");
    check("stray.mrdy", 32'(mem_rready_o), 32'd0);
    step();
    mem_rvalid_i = 1'b0;
    check_quiet("stray2");

    // Reset asserted during WAIT_MEM
    drive_op(1'b1, 3'b010, 1'b1, 5'd10, 32'h0000_4000);
    step();
    valid_i = 1'b0;
    check("rwm.mrdy", 32'(mem_rready_o), 32'd1);
    reset = 1'b0;
    #1;
    check("rwm.mrdy0",  32'(mem_rready_o), 32'd0);
    check("rwm.ready0", 32'(ready_o), 32'd0);
    step(); step();
    reset = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    step();
    mem_rvalid_i = 1'b0;
    check_quiet("rwm.after");
    check("rwm.ready", 32'(ready_o), 32'd1);
    step();
    check_quiet("rwm.after2");

    // Reset asserted during COMMIT
    drive_op(1'b0, 3'b000, 1'b1, 5'd11, 32'h0000_0AAA);
    step();
    valid_i = 1'b0;
    check("rcm.retire", 32'(retire_o), 32'd1);
    reset = 1'b0;
    #1;
    check_quiet("rcm.rst");
    step();
    reset = 1'b1;
    step();
    check("rcm.ready", 32'(ready_o), 32'd1);
    check_quiet("rcm.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
